alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Round-robin scheduler that shares one pipelined `alu` instance between `N_REQ` requesters. It accepts operations on per-requester valid/ready ports, issues at most one operation per cycle into the ALU, and records the issuing requester ID in an in-order tag FIFO. As each result returns, the block pops the FIFO and steers the result back to the originating requester. It sits between the client blocks and the `alu`, and it is the only driver of the ALU's operand and opcode inputs.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `DIN_W`, 8: operand width; matches the `alu` `DIN_W`.
- `DOUT_W`, 2*DIN_W: result width; matches the `alu` `DOUT_W`.
- `MAX_OUTST`, 4: maximum number of operations in flight in the ALU, which is also the tag FIFO depth (1..16).
- `clk`  in  1  the single clock; all logic is on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `req_valid_i`  in  N_REQ  per-requester operation valid.
- `req_ready_o`  out  N_REQ  per-requester accept; one-hot or zero.
- `req_a_i`  in  N_REQ*DIN_W  packed A operands; requester k uses bits [k*DIN_W +: DIN_W].
- `req_b_i`  in  N_REQ*DIN_W  packed B operands, packed the same way as `req_a_i`.
- `req_opcode_i`  in  N_REQ  per-requester `alu_pkg::opcode_t`: 0 = ADD, 1 = MULT.
- `alu_a_o`, `alu_b_o`  out  DIN_W each  operands to the ALU.
- `alu_opcode_o`  out  1  opcode to the ALU.
- `alu_op_valid_o`  out  1  issue strobe to the ALU.
- `alu_data_i`  in  DOUT_W  result from the ALU.
- `alu_data_valid_i`  in  1  result strobe from the ALU; results arrive in issue order.
- `resp_valid_o`  out  N_REQ  one-hot result strobe to the owning requester.
- `resp_data_o`  out  DOUT_W  result bus, shared by all requesters.
- `outst_o`  out  $clog2(MAX_OUTST+1)  current in-flight count.
- `err_o`  out  1  sticky error: a result arrived while the tag FIFO was empty.

## Operation
- Handshake: a transfer occurs for requester k when `req_valid_i[k] && req_ready_o[k]`.
  - A requester may hold `req_valid_i` high across cycles.
  - Its operands and opcode must stay stable until the transfer.
- Grant:
  - `req_ready_o` is combinational from `req_valid_i`, the round-robin pointer and `outst_o`.
  - The grant goes to the first valid requester at or after `rr_ptr`, in wrapping search order.
  - No grant is made when `outst_o == MAX_OUTST`, even if a result returns in the same cycle.
- Pointer update: after a grant to requester k, `rr_ptr` becomes (k+1) mod N_REQ. It holds when there is no grant.
- Issue: on a transfer, the block registers the granted operands and opcode onto the `alu_*` outputs and pulses `alu_op_valid_o` for one cycle. In the same edge it pushes k into the tag FIFO.
- Return: on `alu_data_valid_i` with the FIFO non-empty, the block pops tag k.
  - The next cycle it drives `resp_valid_o` = one-hot(k) and `resp_data_o` = `alu_data_i`.
  - A requester cannot stall a response; every requester must accept a response in any cycle.
- In-flight count `outst_o`:
  - +1 on issue only; −1 on pop only; unchanged when issue and pop happen in the same cycle.
  - It never exceeds MAX_OUTST and never goes below 0.
- Error: `alu_data_valid_i` with the FIFO empty sets `err_o`. No pop occurs, `resp_valid_o` stays 0, and `err_o` clears only on reset.
- Tag FIFO: circular buffer with read and write pointers that wrap modulo MAX_OUTST. A full FIFO plus a simultaneous pop is legal; no push occurs that cycle.

## Timing
- Reset values (asynchronous): `alu_op_valid_o`, `resp_valid_o`, `outst_o`, `err_o`, `rr_ptr` and the FIFO pointers are 0. `alu_a_o`, `alu_b_o`, `alu_opcode_o` and `resp_data_o` are 0.
- Reset mid-operation: all in-flight tags are discarded. Results the ALU returns after `rst` deasserts with an empty FIFO set `err_o`. The system must therefore reset the ALU and the arbiter together.
- Request to `alu_op_valid_o`: 1 cycle.
- `alu_data_valid_i` to `resp_valid_o`: 1 cycle.
- Sustained throughput: one operation per cycle while `outst_o < MAX_OUTST`.
- `req_ready_o` has a combinational path from `req_valid_i`. Requesters must not make `req_valid_i` depend combinationally on `req_ready_o`.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, where the lowest index wins. `rr_ptr` is not implemented and is treated as 0.
  - Undefined (default): round-robin as described under Operation.
- All other behaviour is identical in both configurations.

## Test plan
All scenarios use N_REQ=4, DIN_W=8, MAX_OUTST=4, and an ALU model with a 3-cycle latency.
- Single request: req 2 issues MULT 0x0F × 0x11 → `alu_op_valid_o` pulses 1 cycle later. `resp_valid_o`=4'b0100 with `resp_data_o`=0x00FF arrives 1 cycle after `alu_data_valid_i`.
- Fairness: all four requesters hold valid for 8 cycles → grants go 0,1,2,3,0,1,2,3, each result is routed to the correct one-hot, and `err_o`=0. With `ALU_ARB_FIXED_PRIO_EN` defined, req 0 wins every cycle.
- Full FIFO: the ALU model withholds results; after 4 issues `outst_o`=4 and `req_ready_o`=0. Releasing one result lets exactly one more issue after the pop, and `outst_o` stays ≤4 throughout.
- Simultaneous issue and pop at `outst_o`=2 → `outst_o` stays 2 and responses arrive in order with correct tags. ADD 0xFF+0x01 returns 0x0100.
- Spurious result: `alu_data_valid_i` pulsed with the FIFO empty → `err_o`=1 and stays set, and `resp_valid_o`=0.
- Reset with 3 operations in flight → all outputs reset immediately; the first late result sets `err_o`, and new requests issue normally afterwards.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one pipelined ALU between N_REQ requesters and returns results via an in-order tag FIFO.
// Build option ALU_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module alu_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DIN_W     = 8,
    parameter int DOUT_W    = 2*DIN_W,
    parameter int MAX_OUTST = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_REQ-1:0]               req_valid_i,
    output logic [N_REQ-1:0]               req_ready_o,
    input  logic [N_REQ*DIN_W-1:0]         req_a_i,
    input  logic [N_REQ*DIN_W-1:0]         req_b_i,
    input  logic [N_REQ-1:0]               req_opcode_i,
    output logic [DIN_W-1:0]               alu_a_o,
    output logic [DIN_W-1:0]               alu_b_o,
    output logic                           alu_opcode_o,
    output logic                           alu_op_valid_o,
    input  logic [DOUT_W-1:0]              alu_data_i,
    input  logic                           alu_data_valid_i,
    output logic [N_REQ-1:0]               resp_valid_o,
    output logic [DOUT_W-1:0]              resp_data_o,
    output logic [$clog2(MAX_OUTST+1)-1:0] outst_o,
    output logic                           err_o
);

    localparam int TAG_W = $clog2(N_REQ);
    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CNT_W = $clog2(MAX_OUTST+1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTST);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTST-1);
    localparam logic [TAG_W-1:0] LAST_REQ = TAG_W'(N_REQ-1);

    logic [TAG_W-1:0] base;
    logic [TAG_W-1:0] gnt_idx;
    logic [TAG_W-1:0] cand_idx;
    logic             gnt_any;
    logic             pop;
    int               cand;

    logic [TAG_W-1:0] tag_mem [MAX_OUTST];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign base = '0;
`else
    logic [TAG_W-1:0] rr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (gnt_any) begin
            rr_ptr <= (gnt_idx == LAST_REQ) ? '0 : gnt_idx + TAG_W'(1);
        end
    end

    assign base = rr_ptr;
`endif

    // Wrapping search from base; a full FIFO blocks the grant even if a result returns this cycle.
    always_comb begin
        req_ready_o = '0;
        gnt_idx     = '0;
        gnt_any     = 1'b0;
        cand        = 0;
        cand_idx    = '0;
        if (outst_o != MAX_CNT) begin
            for (int i = 0; i < N_REQ; i++) begin
                cand = int'(base) + i;
                if (cand >= N_REQ) begin
                    cand = cand - N_REQ;
                end
                cand_idx = TAG_W'(cand);
                if (!gnt_any && req_valid_i[cand_idx]) begin
                    gnt_any              = 1'b1;
                    gnt_idx              = cand_idx;
                    req_ready_o[cand_idx] = 1'b1;
                end
            end
        end
    end

    assign pop = alu_data_valid_i && (outst_o != '0);

    always_ff @(posedge clk) begin
        if (gnt_any) begin
            tag_mem[wr_ptr] <= gnt_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a_o        <= '0;
            alu_b_o        <= '0;
            alu_opcode_o   <= 1'b0;
            alu_op_valid_o <= 1'b0;
            resp_valid_o   <= '0;
            resp_data_o    <= '0;
            outst_o        <= '0;
            err_o          <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
        end else begin
            alu_op_valid_o <= gnt_any;
            if (gnt_any) begin
                alu_a_o      <= req_a_i[int'(gnt_idx)*DIN_W +: DIN_W];
                alu_b_o      <= req_b_i[int'(gnt_idx)*DIN_W +: DIN_W];
                alu_opcode_o <= req_opcode_i[gnt_idx];
                wr_ptr       <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            end

            resp_valid_o <= '0;
            if (pop) begin
                resp_valid_o <= N_REQ'(1) << tag_mem[rd_ptr];
                resp_data_o  <= alu_data_i;
                rd_ptr       <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
            end else if (alu_data_valid_i) begin
                err_o <= 1'b1;
            end

            case ({gnt_any, pop})
                2'b10:   outst_o <= outst_o + CNT_W'(1);
                2'b01:   outst_o <= outst_o - CNT_W'(1);
                default: outst_o <= outst_o;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed stimulus, a 3-cycle ALU model, and a queue-based scoreboard checked every cycle.
module tb_alu_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int OW = 16;
    localparam int MX = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid_i = '0;
    logic [N-1:0]    req_ready_o;
    logic [N*DW-1:0] req_a_i = '0;
    logic [N*DW-1:0] req_b_i = '0;
    logic [N-1:0]    req_opcode_i = '0;
    logic [DW-1:0]   alu_a_o, alu_b_o;
    logic            alu_opcode_o, alu_op_valid_o;
    logic [OW-1:0]   alu_data_i = '0;
    logic            alu_data_valid_i = 1'b0;
    logic [N-1:0]    resp_valid_o;
    logic [OW-1:0]   resp_data_o;
    logic [2:0]      outst_o;
    logic            err_o;

    int total = 0;
    int bad   = 0;

    alu_arbiter #(.N_REQ(N), .DIN_W(DW), .DOUT_W(OW), .MAX_OUTST(MX)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_a_i(req_a_i), .req_b_i(req_b_i), .req_opcode_i(req_opcode_i),
        .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_opcode_o(alu_opcode_o),
        .alu_op_valid_o(alu_op_valid_o),
        .alu_data_i(alu_data_i), .alu_data_valid_i(alu_data_valid_i),
        .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o),
        .outst_o(outst_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ALU model: 3-cycle latency, can withhold results, release one, or emit a spurious result
    typedef struct { int due; logic [OW-1:0] d; } pend_t;
    pend_t pipe[$];
    int    cyc = 0;
    bit    alu_hold = 0;
    bit    alu_release_one = 0;
    bit    spurious_req = 0;

    always @(posedge clk) begin
        #2;
        cyc++;
        alu_data_valid_i = 1'b0;
        alu_data_i       = '0;
        if (alu_op_valid_o)
            pipe.push_back('{due: cyc + 3,
                             d: alu_opcode_o ? ({8'h00, alu_a_o} * {8'h00, alu_b_o})
                                             : ({8'h00, alu_a_o} + {8'h00, alu_b_o})});
        if (spurious_req) begin
            alu_data_valid_i = 1'b1;
            alu_data_i       = 16'hDEAD;
            spurious_req     = 0;
        end else if (pipe.size() > 0 && (alu_release_one || (!alu_hold && pipe[0].due <= cyc))) begin
            alu_data_valid_i = 1'b1;
            alu_data_i       = pipe[0].d;
            void'(pipe.pop_front());
            alu_release_one  = 0;
        end
    end

    // Scoreboard: tags in flight as a queue of (requester, expected result)
    typedef struct { int req; logic [OW-1:0] res; } tag_t;
    tag_t         mq[$];
    int           m_ptr = 0;
    bit           m_err = 0;
    bit           e_issue = 0;
    logic [DW-1:0] e_a, e_b;
    logic         e_op;
    logic [N-1:0] e_rv = '0;
    logic [OW-1:0] e_rd = '0;
    int           gnt_log[$];

    function automatic int pick();
        if (mq.size() >= MX) return -1;
        for (int i = 0; i < N; i++) begin
            if (req_valid_i[(m_ptr + i) % N]) return (m_ptr + i) % N;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        int k;
        logic [DW-1:0] a, b;
        tag_t t;
        if (rst) begin
            mq.delete();
            m_ptr = 0; m_err = 0; e_issue = 0; e_rv = '0;
            chk("rst_op_valid", alu_op_valid_o, 0);
            chk("rst_resp_valid", resp_valid_o, 0);
            chk("rst_outst", outst_o, 0);
            chk("rst_err", err_o, 0);
        end else begin
            k = pick();
            chk("ready", req_ready_o, (k >= 0) ? (32'd1 << k) : 32'd0);
            chk("op_valid", alu_op_valid_o, e_issue);
            if (e_issue) begin
                chk("alu_a", alu_a_o, e_a);
                chk("alu_b", alu_b_o, e_b);
                chk("alu_op", alu_opcode_o, e_op);
            end
            chk("resp_valid", resp_valid_o, e_rv);
            if (e_rv != 0) chk("resp_data", resp_data_o, e_rd);
            chk("outst", outst_o, mq.size());
            chk("err", err_o, m_err);
            for (int i = 0; i < N; i++) if (req_ready_o[i]) gnt_log.push_back(i);

            e_rv = '0;
            if (alu_data_valid_i && mq.size() > 0) begin
                t    = mq.pop_front();
                e_rv = N'(1) << t.req;
                e_rd = t.res;
            end else if (alu_data_valid_i) begin
                m_err = 1;
            end
            e_issue = (k >= 0);
            if (k >= 0) begin
                a = req_a_i[k*DW +: DW];
                b = req_b_i[k*DW +: DW];
                e_a = a; e_b = b; e_op = req_opcode_i[k];
                mq.push_back('{req: k, res: e_op ? ({8'h00, a} * {8'h00, b}) : ({8'h00, a} + {8'h00, b})});
`ifndef ALU_ARB_FIXED_PRIO_EN
                m_ptr = (k + 1) % N;
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input bit v, input logic [7:0] a, input logic [7:0] b, input bit op);
        req_valid_i[k]       = v;
        req_a_i[k*DW +: DW]  = a;
        req_b_i[k*DW +: DW]  = b;
        req_opcode_i[k]      = op;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (n < 40 && !(outst_o == 0 && pipe.size() == 0 && !alu_data_valid_i)) begin
            tick();
            n++;
        end
        chk("drain_timeout", (outst_o == 0 && pipe.size() == 0) ? 1 : 0, 1);
    endtask

    task automatic wait_resp(input string name);
        int n;
        n = 0;
        while (n < 20 && resp_valid_o == 0) begin
            tick();
            n++;
        end
        chk(name, (resp_valid_o != 0) ? 1 : 0, 1);
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0, n;
        int exp_gnt[8];

        tick(); tick();
        chk("reset_alu_a", alu_a_o, 0);
        chk("reset_resp_data", resp_data_o, 0);
        chk("reset_outst", outst_o, 0);
        rst = 1'b0;
        tick();

        // single request: MULT 0x0F * 0x11 from requester 2
        set_req(2, 1, 8'h0F, 8'h11, 1);
        tick();
        set_req(2, 0, 8'h0F, 8'h11, 1);
        chk("single_issue", alu_op_valid_o, 1);
        chk("single_a", alu_a_o, 8'h0F);
        wait_resp("single_resp_timeout");
        chk("single_resp_valid", resp_valid_o, 4'b0100);
        chk("single_resp_data", resp_data_o, 16'h00FF);
        drain();

        // fairness with all four requesters held valid
        rst_pulse();
        n0 = gnt_log.size();
        for (int k = 0; k < N; k++) set_req(k, 1, 8'(k + 1), 8'(16 * (k + 1)), k[0]);
        n = 0;
        while (n < 40 && gnt_log.size() < n0 + 8) begin
            tick();
            n++;
        end
        req_valid_i = '0;
        chk("fair_timeout", (gnt_log.size() >= n0 + 8) ? 1 : 0, 1);
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_gnt = '{0, 0, 0, 0, 0, 0, 0, 0};
`else
        exp_gnt = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
        for (int i = 0; i < 8; i++)
            if (n0 + i < gnt_log.size()) chk($sformatf("fair_gnt%0d", i), gnt_log[n0 + i], exp_gnt[i]);
        drain();
        chk("fair_err", err_o, 0);

        // full FIFO: withhold results, then release exactly one
        alu_hold = 1;
        for (int k = 0; k < N; k++) set_req(k, 1, 8'(k + 3), 8'(k + 5), 0);
        for (int i = 0; i < 8; i++) tick();
        chk("full_outst", outst_o, 4);
        chk("full_ready", req_ready_o, 0);
        n0 = gnt_log.size();
        alu_release_one = 1;
        for (int i = 0; i < 6; i++) tick();
        chk("full_one_more", gnt_log.size(), n0 + 1);
        chk("full_outst_after", outst_o, 4);
        req_valid_i = '0;
        alu_hold = 0;
        drain();

        // simultaneous issue and pop at two in flight
        set_req(0, 1, 8'hFF, 8'h01, 0);
        tick();
        set_req(0, 0, 8'hFF, 8'h01, 0);
        set_req(1, 1, 8'h12, 8'h34, 1);
        tick();
        set_req(1, 0, 8'h12, 8'h34, 1);
        tick();
        tick();
        chk("sim_outst_before", outst_o, 2);
        set_req(3, 1, 8'h20, 8'h02, 1);
        tick();
        set_req(3, 0, 8'h20, 8'h02, 1);
        chk("sim_outst", outst_o, 2);
        chk("sim_issue", alu_op_valid_o, 1);
        chk("sim_resp0_valid", resp_valid_o, 4'b0001);
        chk("sim_resp0_data", resp_data_o, 16'h0100);
        tick();
        chk("sim_resp1_valid", resp_valid_o, 4'b0010);
        chk("sim_resp1_data", resp_data_o, 16'h03A8);
        drain();

        // spurious result with empty FIFO
        spurious_req = 1;
        tick();
        tick();
        chk("spur_err", err_o, 1);
        chk("spur_resp", resp_valid_o, 0);
        for (int i = 0; i < 4; i++) tick();
        chk("spur_err_sticky", err_o, 1);

        // reset with operations in flight
        rst_pulse();
        n0 = gnt_log.size();
        set_req(1, 1, 8'h05, 8'h06, 0);
        n = 0;
        while (n < 10 && gnt_log.size() < n0 + 3) begin
            tick();
            n++;
        end
        chk("rst3_issued", gnt_log.size(), n0 + 3);
        rst = 1'b1;
        req_valid_i = '0;
        #1;
        chk("rst3_outst", outst_o, 0);
        chk("rst3_op_valid", alu_op_valid_o, 0);
        chk("rst3_resp", resp_valid_o, 0);
        tick();
        rst = 1'b0;
        n = 0;
        while (n < 10 && !err_o) begin
            tick();
            n++;
        end
        chk("rst3_late_err", err_o, 1);
        drain();
        set_req(2, 1, 8'h03, 8'h04, 0);
        tick();
        set_req(2, 0, 8'h03, 8'h04, 0);
        wait_resp("rst3_resp_timeout");
        chk("rst3_new_valid", resp_valid_o, 4'b0100);
        chk("rst3_new_data", resp_data_o, 16'h0007);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
